// File: rtl/mux_gate_checker_pkg.sv
// Shared types and constants for the gate-block checker: FSM states,
// stimulus vector table and the golden truth table of the gate block.
package mux_gate_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int NUM_VEC = 4;

    // Element i holds {a,b} for vector i.
    localparam logic [NUM_VEC-1:0][1:0] VEC_TABLE = {2'b11, 2'b10, 2'b01, 2'b00};

    function automatic logic [2:0] golden(input logic a, input logic b);
        return {a & b, a | b, ~a};
    endfunction

endpackage

// File: rtl/mux_gate_checker_if.sv
// Stimulus/response and result bundle between the checker and its environment.
interface mux_gate_checker_if;
    logic       start;
    logic       and_in;
    logic       or_in;
    logic       not_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [3:0] fail_vec;

    modport master (
        output start, and_in, or_in, not_in,
        input  a_out, b_out, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, and_in, or_in, not_in,
        output a_out, b_out, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/mux_gate_checker_gate_golden_model.sv
// Combinational reference for the gate block: expected {and,or,not} for (a,b)
// and the per-gate mismatch against the sampled gate outputs.
module gate_golden_model
    import mux_gate_chk_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [2:0] sampled,
    output logic [2:0] mismatch
);
    logic [2:0] expected;

    assign expected = golden(a, b);
    assign mismatch = expected ^ sampled;
endmodule

// File: rtl/mux_gate_checker.sv
// Sweeps all four (a,b) vectors into the gate block, samples its outputs after
// a settle interval and scores them against the golden truth table.
module mux_gate_checker
    import mux_gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_gate_checker_if.slave  bus
);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_IDX    = 2'(NUM_VEC - 1);

    state_t     state, state_nxt;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic       a_r, b_r, done_r, pass_r;
    logic [3:0] err_r, fail_r;
    logic [2:0] mismatch;

    function automatic logic [3:0] ones3(input logic [2:0] m);
        return 4'(m[0]) + 4'(m[1]) + 4'(m[2]);
    endfunction

    gate_golden_model u_golden (
        .a        (a_r),
        .b        (b_r),
        .sampled  ({bus.and_in, bus.or_in, bus.not_in}),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = APPLY;
            APPLY:   state_nxt = SETTLE;
            SETTLE:  if (cnt == 4'd0) state_nxt = CHECK;
            CHECK:   state_nxt = (idx == LAST_IDX) ? DONE : APPLY;
            DONE:    if (bus.start) state_nxt = APPLY;
            default: state_nxt = IDLE;
        endcase
    end

    // Scoreboard and stimulus registers; gate outputs are only looked at in CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= 2'd0;
            cnt    <= 4'd0;
            a_r    <= 1'b0;
            b_r    <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            err_r  <= 4'd0;
            fail_r <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        idx    <= 2'd0;
                        done_r <= 1'b0;
                        pass_r <= 1'b0;
                        err_r  <= 4'd0;
                        fail_r <= 4'd0;
                    end else if (state == DONE) begin
                        done_r <= 1'b1;
                        pass_r <= (err_r == 4'd0);
                    end
                end
                APPLY: begin
                    {a_r, b_r} <= VEC_TABLE[idx];
                    cnt        <= SETTLE_INIT;
                end
                SETTLE: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                CHECK: begin
                    err_r <= err_r + ones3(mismatch);
                    if (|mismatch) fail_r[idx] <= 1'b1;
                    if (idx != LAST_IDX) idx <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.a_out     = a_r;
    assign bus.b_out     = b_r;
    assign bus.busy      = (state == APPLY) || (state == SETTLE) || (state == CHECK);
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
    assign bus.err_count = err_r;
    assign bus.fail_vec  = fail_r;
endmodule

// File: tb/tb_mux_gate_checker.sv
// Directed bench: two checkers (settle 2 and 5) around a behavioural gate block
// with injectable stuck-at faults.
module tb_mux_gate_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_gate_checker_if bus0();
    mux_gate_checker_if bus1();

    logic and_sa0 = 1'b0;
    logic or_sa1  = 1'b0;
    logic not_sa0 = 1'b0;

    assign bus0.and_in = and_sa0 ? 1'b0 : (bus0.a_out & bus0.b_out);
    assign bus0.or_in  = or_sa1  ? 1'b1 : (bus0.a_out | bus0.b_out);
    assign bus0.not_in = not_sa0 ? 1'b0 : ~bus0.a_out;

    assign bus1.and_in = bus1.a_out & bus1.b_out;
    assign bus1.or_in  = bus1.a_out | bus1.b_out;
    assign bus1.not_in = ~bus1.a_out;

    mux_gate_checker #(.SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mux_gate_checker #(.SETTLE_CYCLES(5)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int compared = 0;
    int mismatched = 0;
    int lat;
    logic [1:0] trace [0:255];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit sel);
        @(negedge clk);
        if (sel) bus1.start = 1'b1; else bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    // Counts edges after the start edge until done, logging {a_out,b_out}.
    task automatic wait_done(input bit sel, output int l);
        l = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            trace[c] = sel ? {bus1.a_out, bus1.b_out} : {bus0.a_out, bus0.b_out};
            if (sel ? bus1.done : bus0.done) begin
                l = c;
                break;
            end
        end
    endtask

    task automatic check_results(input string tag, input logic pass, input logic [3:0] err,
                                 input logic [3:0] fail);
        check({tag, "_done"}, 32'(bus0.done), 32'd1);
        check({tag, "_pass"}, 32'(bus0.pass), 32'(pass));
        check({tag, "_err"},  32'(bus0.err_count), 32'(err));
        check({tag, "_fail"}, 32'(bus0.fail_vec), 32'(fail));
        check({tag, "_busy"}, 32'(bus0.busy), 32'd0);
    endtask

    initial begin
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ab",   32'({bus0.a_out, bus0.b_out}), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_done", 32'({bus0.done, bus0.pass}), 32'd0);
        check("rst_regs", 32'({bus0.err_count, bus0.fail_vec}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean sweep, settle 2
        pulse(1'b0);
        check("t1_busy", 32'(bus0.busy), 32'd1);
        wait_done(1'b0, lat);
        check("t1_lat", 32'(lat), 32'd17);
        check("t1_v0", 32'(trace[1]), 32'd0);
        check("t1_v1", 32'(trace[5]), 32'd1);
        check("t1_v2", 32'(trace[9]), 32'd2);
        check("t1_v2hold", 32'(trace[12]), 32'd2);
        check("t1_v3", 32'(trace[13]), 32'd3);
        check_results("t1", 1'b1, 4'd0, 4'b0000);

        // AND stuck-at-0
        and_sa0 = 1'b1;
        pulse(1'b0);
        wait_done(1'b0, lat);
        check("t2_lat", 32'(lat), 32'd17);
        check_results("t2", 1'b0, 4'd1, 4'b1000);

        // Restart from DONE clears the scoreboard
        and_sa0 = 1'b0;
        pulse(1'b0);
        check("t5_clr_done", 32'({bus0.done, bus0.pass}), 32'd0);
        check("t5_clr_regs", 32'({bus0.err_count, bus0.fail_vec}), 32'd0);
        check("t5_clr_busy", 32'(bus0.busy), 32'd1);
        wait_done(1'b0, lat);
        check("t5_re_lat", 32'(lat), 32'd17);
        check_results("t5re", 1'b1, 4'd0, 4'b0000);

        // NOT stuck-at-0 and OR stuck-at-1
        not_sa0 = 1'b1;
        or_sa1  = 1'b1;
        pulse(1'b0);
        wait_done(1'b0, lat);
        check("t3_lat", 32'(lat), 32'd17);
        check_results("t3", 1'b0, 4'd3, 4'b0011);
        not_sa0 = 1'b0;
        or_sa1  = 1'b0;

        // Start while busy is ignored
        pulse(1'b0);
        repeat (5) @(posedge clk);
        pulse(1'b0);
        wait_done(1'b0, lat);
        check("t5_busy_lat", 32'(lat), 32'd11);
        repeat (3) @(posedge clk);
        #1;
        check("t5_noqueue_busy", 32'(bus0.busy), 32'd0);
        check("t5_noqueue_done", 32'(bus0.done), 32'd1);

        // Reset during SETTLE of vector 2
        not_sa0 = 1'b1;
        pulse(1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("t4_pre_ab",   32'({bus0.a_out, bus0.b_out}), 32'd2);
        check("t4_pre_err",  32'(bus0.err_count), 32'd2);
        check("t4_pre_fail", 32'(bus0.fail_vec), 32'b0011);
        rst_n = 1'b0;
        #1;
        check("t4_rst_ab",   32'({bus0.a_out, bus0.b_out}), 32'd0);
        check("t4_rst_busy", 32'(bus0.busy), 32'd0);
        check("t4_rst_regs", 32'({bus0.err_count, bus0.fail_vec}), 32'd0);
        @(posedge clk);
        #1;
        check("t4_rst_hold", 32'({bus0.busy, bus0.done, bus0.pass}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        not_sa0 = 1'b0;
        pulse(1'b0);
        wait_done(1'b0, lat);
        check("t4_lat", 32'(lat), 32'd17);
        check_results("t4", 1'b1, 4'd0, 4'b0000);

        // Settle 5
        pulse(1'b1);
        wait_done(1'b1, lat);
        check("t6_lat", 32'(lat), 32'd29);
        for (int i = 0; i < 4; i++) begin
            check("t6_first", 32'(trace[1 + 7*i]), 32'(i));
            check("t6_last",  32'(trace[7 + 7*i]), 32'(i));
        end
        check("t6_pass", 32'({bus1.done, bus1.pass}), 32'b11);
        check("t6_regs", 32'({bus1.err_count, bus1.fail_vec}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
